// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: fetch PC owner, one-outstanding imem requester and decode-side FIFO
module inst_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  output logic                     o_mem_req,
  output logic [31:0]              o_mem_addr,
  input  logic                     i_mem_ack,
  input  logic [31:0]              i_mem_rdata,
  output logic                     o_dec_valid,
  input  logic                     i_dec_ready,
  output logic [31:0]              o_dec_inst,
  output logic [31:0]              o_dec_npc,
  input  logic                     i_redirect,
  input  logic [31:0]              i_redirect_pc,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;
  state_t r_state, w_state_next;
  logic [31:0] r_fetch_pc, r_req_addr, w_fetch_pc_next;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count, w_count_next;
  logic [31:0] r_inst [DEPTH];
  logic [31:0] r_npc [DEPTH];
  logic w_push, w_pop, w_space, w_new_req;
  assign w_push          = (r_state == REQ) && i_mem_ack && !i_redirect;
  assign w_pop           = o_dec_valid && i_dec_ready && !i_redirect;
  assign w_count_next    = r_count + CW'(w_push) - CW'(w_pop);
  assign w_space         = w_count_next < FULL;
  assign w_fetch_pc_next = i_redirect ? i_redirect_pc : w_push ? r_fetch_pc + 32'd4 : r_fetch_pc;
  assign w_new_req       = (w_state_next == REQ) && ((r_state == IDLE) || i_mem_ack);
  // state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_state_next;
  end
  // next state: redirect keeps an unacked request alive as DISCARD, otherwise issue while room remains
  always_comb begin
    w_state_next = r_state;
    if (i_redirect) w_state_next = (r_state == DISCARD || (r_state == REQ && !i_mem_ack)) ? DISCARD : REQ;
    else if (r_state == IDLE) w_state_next = w_space ? REQ : IDLE;
    else if (i_mem_ack) w_state_next = (r_state == DISCARD || w_space) ? REQ : IDLE;
  end
  // outputs: request from state, decode view of the FIFO head (zero when empty)
  always_comb begin
    o_mem_req   = r_state != IDLE;
    o_mem_addr  = r_req_addr;
    o_dec_valid = r_count != '0;
    o_dec_inst  = o_dec_valid ? r_inst[r_rd_ptr] : '0;
    o_dec_npc   = o_dec_valid ? r_npc[r_rd_ptr] : '0;
    o_count     = r_count;
  end
  // fetch PC, request address and FIFO bookkeeping; redirect flushes and retargets
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_fetch_pc <= w_fetch_pc_next;
      if (w_new_req) r_req_addr <= w_fetch_pc_next;
      r_count  <= i_redirect ? '0 : w_count_next;
      r_wr_ptr <= i_redirect ? '0 : r_wr_ptr + AW'(w_push);
      r_rd_ptr <= i_redirect ? '0 : r_rd_ptr + AW'(w_pop);
    end
  end
  // FIFO storage: returned word with its PC+4
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_inst[r_wr_ptr] <= i_mem_rdata;
      r_npc[r_wr_ptr]  <= r_fetch_pc + 32'd4;
    end
  end
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb_inst_prefetch_queue: random and directed checks against a queue-based fetch model
module tb_inst_prefetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  logic clk = 1'b0;
  logic rst_n, mem_req, mem_ack, dec_valid, dec_ready, redirect;
  logic [31:0] mem_addr, mem_rdata, dec_inst, dec_npc, redirect_pc;
  logic [2:0] count;
  int n_chk = 0, n_pass = 0;
  typedef struct {logic [31:0] inst; logic [31:0] npc;} ent_t;
  ent_t q[$];
  logic [31:0] m_pc, m_addr;
  bit m_busy, m_drop, req_seen;
  int w = 0;

  inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_mem_req(mem_req), .o_mem_addr(mem_addr),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata), .o_dec_valid(dec_valid),
    .i_dec_ready(dec_ready), .o_dec_inst(dec_inst), .o_dec_npc(dec_npc),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc), .o_count(count));

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_step();
    if (!rst_n) begin
      q.delete(); m_pc = RESET_PC; m_busy = 0; m_drop = 0;
    end else if (redirect) begin
      q.delete(); m_pc = redirect_pc;
      if (m_busy && (m_drop || !mem_ack)) m_drop = 1;
      else begin m_busy = 1; m_drop = 0; m_addr = redirect_pc; end
    end else begin
      if (q.size() > 0 && dec_ready) void'(q.pop_front());
      if (m_busy && mem_ack) begin
        if (!m_drop) begin q.push_back('{mem_rdata, m_pc + 32'd4}); m_pc = m_pc + 32'd4; end
        m_busy = 0;
      end
      if (!m_busy && q.size() < DEPTH) begin m_busy = 1; m_drop = 0; m_addr = m_pc; end
    end
  endtask

  // lat >= 0: ack after lat waiting cycles; lat < 0: random ack
  task automatic cyc(input int lat, input int rdy_pct, input bit redir, input logic [31:0] rpc, input bit rstv);
    @(negedge clk);
    check("mem_req", mem_req, m_busy);
    if (m_busy) check("mem_addr", mem_addr, m_addr);
    check("dec_valid", dec_valid, q.size() != 0);
    check("dec_inst", dec_inst, q.size() != 0 ? q[0].inst : 32'h0);
    check("dec_npc", dec_npc, q.size() != 0 ? q[0].npc : 32'h0);
    check("count", count, q.size());
    req_seen = mem_req;
    rst_n = rstv;
    dec_ready = $urandom_range(99) < rdy_pct;
    mem_ack = mem_req && (lat < 0 ? $urandom_range(99) < 40 : w >= lat);
    mem_rdata = mem_ack ? word(mem_addr) : $urandom;
    redirect = redir;
    redirect_pc = rpc;
    @(posedge clk);
    model_step();
    w = (!rst_n || !req_seen || mem_ack) ? 0 : w + 1;
  endtask

  initial begin
    bit hit;
    rst_n = 0; mem_ack = 0; mem_rdata = 0; dec_ready = 0; redirect = 0; redirect_pc = 0;
    repeat (2) @(posedge clk);
    q.delete(); m_pc = RESET_PC; m_busy = 0; m_drop = 0;
    // zero-wait streaming from reset: one address per cycle
    for (int i = 0; i < 8; i++) begin
      cyc(0, 100, 0, 0, 1);
      #1 check("zw_addr", mem_addr, 32'(4 * i));
    end
    // stall decode: exactly DEPTH fetches then idle
    cyc(0, 100, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 1);
    #1 check("full_cnt", count, 32'd4);
    check("full_req", mem_req, 32'd0);
    check("full_head", dec_inst, word(32'h0));
    cyc(0, 100, 0, 0, 1);
    #1 check("resume_addr", mem_addr, 32'h10);
    check("resume_req", mem_req, 32'd1);
    // 3-cycle memory, redirect while request to 8 is pending
    cyc(0, 100, 0, 0, 0);
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin cyc(3, 0, 0, 0, 1); #1 hit = mem_req && mem_addr == 32'h8; end
    check("to_req8", hit, 1);
    cyc(3, 0, 0, 0, 1);
    cyc(3, 0, 1, 32'h100, 1);
    #1 check("hold8", mem_addr, 32'h8);
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin cyc(3, 0, 0, 0, 1); #1 hit = dec_valid; end
    check("to_valid", hit, 1);
    check("redir_npc", dec_npc, 32'h104);
    check("redir_inst", dec_inst, word(32'h100));
    // redirect coinciding with the ack that fills the queue
    hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin cyc(3, 0, 0, 0, 1); #1 hit = count == 3 && mem_req; end
    check("to_cnt3", hit, 1);
    cyc(0, 100, 1, 32'h300, 1);
    #1 check("flush_cnt", count, 32'd0);
    check("flush_addr", mem_addr, 32'h300);
    // wrap of fetch PC
    cyc(0, 0, 1, 32'hFFFF_FFFC, 1);
    #1 check("wrap_addr0", mem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 1);
    #1 check("wrap_addr1", mem_addr, 32'h0);
    check("wrap_npc", dec_npc, 32'h0);
    // reset while discarding
    cyc(50, 100, 0, 0, 1);
    cyc(50, 100, 0, 0, 1);
    cyc(50, 100, 1, 32'h200, 1);
    cyc(50, 100, 0, 0, 0);
    #1 check("rst_req", mem_req, 32'd0);
    check("rst_cnt", count, 32'd0);
    check("rst_valid", dec_valid, 32'd0);
    cyc(0, 100, 0, 0, 1);
    #1 check("rst_addr", mem_addr, RESET_PC);
    check("rst_req1", mem_req, 32'd1);
    // random traffic
    for (int i = 0; i < 1500; i++)
      cyc(-1, 70, $urandom_range(99) < 5, $urandom, $urandom_range(99) != 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
